// File: rtl/bus_cfg_pkg.sv
// Shared configuration for the 8088 bus-side controller: defaults, FSM state
// encoding and the region compare helper used by the chip-select decoder.
package bus_cfg_pkg;

  localparam int ADDR_W_DEF = 20;
  localparam int WS_W_DEF   = 3;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD} ws_state_t;

  // Operands are widened to 32 bits so one helper serves any ADDR_W up to 32.
  function automatic logic region_match(input logic [31:0] addr,
                                        input logic        iom,
                                        input logic [31:0] base,
                                        input logic [31:0] mask,
                                        input logic        io);
    return (iom == io) && ((addr & mask) == (base & mask));
  endfunction

endpackage

// File: rtl/cs_decode.sv
// Combinational priority decoder: maps an incoming {address, IO/mem} to the
// winning region. The lowest-numbered matching region wins.
module cs_decode
  import bus_cfg_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int NUM_REGIONS = 4,
  parameter int IDX_W       = 2,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE = '0,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK = '0,
  parameter logic [NUM_REGIONS-1:0]        REGION_IO   = '0
) (
  input  logic [ADDR_W-1:0]      addr,
  input  logic                   iom,
  output logic                   hit,
  output logic [IDX_W-1:0]       idx,
  output logic [NUM_REGIONS-1:0] cs_n_next
);

  always_comb begin
    hit       = 1'b0;
    idx       = '0;
    cs_n_next = '1;
    // Walk from the highest index down so the lowest match is the last write.
    for (int k = NUM_REGIONS - 1; k >= 0; k--) begin
      if (region_match(32'(addr), iom,
                       32'(REGION_BASE[k*ADDR_W +: ADDR_W]),
                       32'(REGION_MASK[k*ADDR_W +: ADDR_W]),
                       REGION_IO[k])) begin
        hit          = 1'b1;
        idx          = IDX_W'(k);
        cs_n_next    = '1;
        cs_n_next[k] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/bus_cs_wait_ctrl.sv
// 8088 min-mode bus controller: ALE address capture, table-driven chip
// selects and a per-region wait-state generator driving READY.
module bus_cs_wait_ctrl
  import bus_cfg_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int NUM_REGIONS = 4,
  parameter int WS_W        = WS_W_DEF,
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_BASE =
    {20'h01C00, 20'h0FF00, 20'h80000, 20'h00000},
  parameter logic [NUM_REGIONS*ADDR_W-1:0] REGION_MASK =
    {20'h0FE00, 20'h0FFF0, 20'h80000, 20'h80000},
  parameter logic [NUM_REGIONS-1:0]        REGION_IO   = 4'b1100,
  parameter logic [NUM_REGIONS*WS_W-1:0]   REGION_WS   =
    {3'd3, 3'd2, 3'd1, 3'd0},
  localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  input  logic                   ALE,
  input  logic                   IOM,
  input  logic [ADDR_W-9:0]      A,
  input  logic [7:0]             AD,
  input  logic                   RD_N,
  input  logic                   WR_N,
  input  logic                   ERR_CLR,
  output logic [ADDR_W-1:0]      ADDR_Q,
  output logic [NUM_REGIONS-1:0] CS_N,
  output logic [IDX_W-1:0]       REGION_IDX,
  output logic                   HIT,
  output logic                   READY,
  output logic                   DECODE_ERR
);

  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic [NUM_REGIONS-1:0] cs_n_q, cs_n_d, dec_cs_n;
  logic [IDX_W-1:0]       idx_q, idx_d, dec_idx;
  logic                   hit_q, hit_d, dec_hit;
  logic                   ready_q, ready_d;
  logic                   err_q, err_d;
  logic [WS_W-1:0]        cnt_q, cnt_d, ws_n;
  ws_state_t              state_q, state_d;
  logic                   strobe, both_low;

  cs_decode #(
    .ADDR_W      (ADDR_W),
    .NUM_REGIONS (NUM_REGIONS),
    .IDX_W       (IDX_W),
    .REGION_BASE (REGION_BASE),
    .REGION_MASK (REGION_MASK),
    .REGION_IO   (REGION_IO)
  ) u_dec (
    .addr      ({A, AD}),
    .iom       (IOM),
    .hit       (dec_hit),
    .idx       (dec_idx),
    .cs_n_next (dec_cs_n)
  );

  always_comb begin
    strobe   = (!RD_N) ^ (!WR_N);
    both_low = !RD_N && !WR_N;
    ws_n     = REGION_WS[idx_q*WS_W +: WS_W];

    addr_d  = addr_q;
    cs_n_d  = cs_n_q;
    idx_d   = idx_q;
    hit_d   = hit_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    ready_d = ready_q;
    err_d   = err_q;

    // A new ALE aborts any cycle in flight and restarts the FSM.
    if (ALE) begin
      addr_d  = {A, AD};
      cs_n_d  = dec_cs_n;
      idx_d   = dec_idx;
      hit_d   = dec_hit;
      state_d = IDLE;
      cnt_d   = '0;
      ready_d = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (strobe) begin
          if (hit_q && ws_n != '0) begin
            state_d = WAIT;
            cnt_d   = ws_n;
            ready_d = 1'b0;
          end else begin
            state_d = HOLD;
          end
        end
        WAIT: if (cnt_q <= WS_W'(1)) begin
          state_d = HOLD;
          cnt_d   = '0;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q - WS_W'(1);
        end
        HOLD: if (RD_N && WR_N) state_d = IDLE;
        default: begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
      endcase
    end

    // Set beats clear when both land on the same edge.
    if (ERR_CLR) err_d = 1'b0;
    if ((strobe && !hit_q) || both_low) err_d = 1'b1;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      addr_q  <= '0;
      cs_n_q  <= '1;
      idx_q   <= '0;
      hit_q   <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      err_q   <= 1'b0;
    end else begin
      addr_q  <= addr_d;
      cs_n_q  <= cs_n_d;
      idx_q   <= idx_d;
      hit_q   <= hit_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end

  assign ADDR_Q     = addr_q;
  assign CS_N       = cs_n_q;
  assign REGION_IDX = idx_q;
  assign HIT        = hit_q;
  assign READY      = ready_q;
  assign DECODE_ERR = err_q;

endmodule

// File: tb/tb_bus_cs_wait_ctrl.sv
// Directed bench for bus_cs_wait_ctrl: decode, wait-state length, error flag,
// async reset and ALE abort, all against hand-computed expectations.
module tb_bus_cs_wait_ctrl;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        ALE = 1'b0;
  logic        IOM = 1'b0;
  logic [11:0] A = '0;
  logic [7:0]  AD = '0;
  logic        RD_N = 1'b1;
  logic        WR_N = 1'b1;
  logic        ERR_CLR = 1'b0;
  logic [19:0] ADDR_Q;
  logic [3:0]  CS_N;
  logic [1:0]  REGION_IDX;
  logic        HIT;
  logic        READY;
  logic        DECODE_ERR;

  int total = 0;
  int bad   = 0;

  bus_cs_wait_ctrl dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .ALE        (ALE),
    .IOM        (IOM),
    .A          (A),
    .AD         (AD),
    .RD_N       (RD_N),
    .WR_N       (WR_N),
    .ERR_CLR    (ERR_CLR),
    .ADDR_Q     (ADDR_Q),
    .CS_N       (CS_N),
    .REGION_IDX (REGION_IDX),
    .HIT        (HIT),
    .READY      (READY),
    .DECODE_ERR (DECODE_ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic latch(input logic [19:0] addr, input logic iom);
    ALE = 1'b1; A = addr[19:8]; AD = addr[7:0]; IOM = iom;
    step();
    ALE = 1'b0;
  endtask

  // One full bus cycle: capture, check decode, strobe, count READY-low cycles.
  task automatic access(input string tag, input logic [19:0] addr, input logic iom,
                        input logic rd_n, input logic wr_n,
                        input logic [3:0] exp_cs, input logic exp_hit,
                        input logic [1:0] exp_idx, input int exp_low,
                        input logic exp_err);
    int low;
    latch(addr, iom);
    chk({tag, " addr"}, 32'(ADDR_Q), 32'(addr));
    chk({tag, " cs_n"}, 32'(CS_N), 32'(exp_cs));
    chk({tag, " hit"}, 32'(HIT), 32'(exp_hit));
    chk({tag, " idx"}, 32'(REGION_IDX), 32'(exp_idx));
    RD_N = rd_n; WR_N = wr_n;
    low = 0;
    repeat (8) begin
      step();
      if (READY !== 1'b1) low++;
    end
    chk({tag, " ready_low"}, 32'(low), 32'(exp_low));
    chk({tag, " err"}, 32'(DECODE_ERR), 32'(exp_err));
    RD_N = 1'b1; WR_N = 1'b1;
    step();
  endtask

  task automatic clear_err();
    ERR_CLR = 1'b1;
    step();
    ERR_CLR = 1'b0;
  endtask

  initial begin
    step();
    step();
    chk("rst addr", 32'(ADDR_Q), 32'h0);
    chk("rst cs_n", 32'(CS_N), 32'hF);
    chk("rst idx", 32'(REGION_IDX), 32'h0);
    chk("rst hit", 32'(HIT), 32'h0);
    chk("rst ready", 32'(READY), 32'h1);
    chk("rst err", 32'(DECODE_ERR), 32'h0);
    RESET_N = 1'b1;
    step();

    // Region 1: memory at 0x80010, one wait state; RD_N two cycles after ALE.
    latch(20'h80010, 1'b0);
    chk("r1 cs_n", 32'(CS_N), 32'hD);
    chk("r1 idx", 32'(REGION_IDX), 32'h1);
    step();
    RD_N = 1'b0;
    step();
    chk("r1 ready w0", 32'(READY), 32'h0);
    step();
    chk("r1 ready w1", 32'(READY), 32'h1);
    RD_N = 1'b1;
    step();

    access("mem400", 20'h00400, 1'b0, 1'b0, 1'b1, 4'hE, 1'b1, 2'd0, 0, 1'b0);
    access("ioFF05", 20'h0FF05, 1'b1, 1'b1, 1'b0, 4'hB, 1'b1, 2'd2, 2, 1'b0);
    access("io1C20", 20'h01C20, 1'b1, 1'b1, 1'b0, 4'h7, 1'b1, 2'd3, 3, 1'b0);
    access("io0040", 20'h00040, 1'b1, 1'b0, 1'b1, 4'hF, 1'b0, 2'd0, 0, 1'b1);
    chk("err sticky", 32'(DECODE_ERR), 32'h1);
    clear_err();
    chk("err clr", 32'(DECODE_ERR), 32'h0);

    access("both_low", 20'h01C00, 1'b1, 1'b0, 1'b0, 4'h7, 1'b1, 2'd3, 0, 1'b1);
    // Clear and set in the same edge: the set wins.
    RD_N = 1'b0; WR_N = 1'b0; ERR_CLR = 1'b1;
    step();
    chk("set wins", 32'(DECODE_ERR), 32'h1);
    RD_N = 1'b1; WR_N = 1'b1;
    step();
    ERR_CLR = 1'b0;
    chk("err clr2", 32'(DECODE_ERR), 32'h0);

    // Async reset in the middle of a region-3 wait.
    latch(20'h01C00, 1'b1);
    WR_N = 1'b0;
    step();
    chk("mid ready low", 32'(READY), 32'h0);
    #1 RESET_N = 1'b0;
    #1;
    chk("async ready", 32'(READY), 32'h1);
    chk("async cs_n", 32'(CS_N), 32'hF);
    WR_N = 1'b1;
    step();
    RESET_N = 1'b1;
    step();

    // ALE while a region-3 wait has cnt=2 left: abort and decode region 1.
    latch(20'h01C00, 1'b1);
    WR_N = 1'b0;
    step();
    step();
    chk("abort pre", 32'(READY), 32'h0);
    WR_N = 1'b1;
    latch(20'h80010, 1'b0);
    chk("abort ready", 32'(READY), 32'h1);
    chk("abort cs_n", 32'(CS_N), 32'hD);
    RD_N = 1'b0;
    step();
    chk("restart w0", 32'(READY), 32'h0);
    step();
    chk("restart w1", 32'(READY), 32'h1);
    RD_N = 1'b1;
    step();
    chk("final err", 32'(DECODE_ERR), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
